// File: rtl/wub_input_scanner.sv
// rtl/wub_input_scanner.sv - N-channel input synchroniser/debouncer with event FIFO (optional WUB_SCAN_TIMESTAMP_EN)
module wub_input_scanner #(
    parameter int                NUM_CH          = 5,
    parameter int                DEBOUNCE_CYCLES = 10000,
    parameter int                FIFO_DEPTH      = 8,
    parameter logic [NUM_CH-1:0] INIT_LEVEL      = {NUM_CH{1'b0}},
    parameter int                TS_W            = 16,
    localparam int               CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int               CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] level,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_chan,
    output logic              evt_level,
`ifdef WUB_SCAN_TIMESTAMP_EN
    output logic [TS_W-1:0]   evt_time,
`endif
    output logic [CNT_W-1:0]  evt_count,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int DBC_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef WUB_SCAN_TIMESTAMP_EN
    localparam int E_W   = CH_W + 1 + TS_W;
`else
    localparam int E_W   = CH_W + 1;
`endif

    logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_CH-1:0] level_q, level_d, pend_q, pend_d, pend_lvl_q, pend_lvl_d;
    logic [NUM_CH-1:0] qual;
    logic [DBC_W-1:0]  cnt_q [NUM_CH];
    logic [DBC_W-1:0]  cnt_d [NUM_CH];
    logic [E_W-1:0]    mem_q [FIFO_DEPTH];
    logic [E_W-1:0]    mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, ovf_set;
    logic              found, push, pop, push_lvl;
    logic [CH_W-1:0]   push_idx;
    logic [E_W-1:0]    push_entry, head;
`ifdef WUB_SCAN_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_q, ts_d, push_ts;
    logic [TS_W-1:0]   pend_ts_q [NUM_CH];
    logic [TS_W-1:0]   pend_ts_d [NUM_CH];
`endif

    // Synchroniser shift and per-channel debounce counters; qual marks an accepted level change
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        level_d = level_q;
        qual    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                    qual[i]    = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Fixed-priority arbiter: lowest pending channel, pushed only if a slot is free after this cycle's pop
    always_comb begin
        found    = 1'b0;
        push_idx = '0;
        push_lvl = 1'b0;
`ifdef WUB_SCAN_TIMESTAMP_EN
        push_ts  = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend_q[i] && !found) begin
                found    = 1'b1;
                push_idx = CH_W'(i);
                push_lvl = pend_lvl_q[i];
`ifdef WUB_SCAN_TIMESTAMP_EN
                push_ts  = pend_ts_q[i];
`endif
            end
        end
        pop  = (count_q != '0) && evt_ready;
        push = found && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
`ifdef WUB_SCAN_TIMESTAMP_EN
        push_entry = {push_idx, push_lvl, push_ts};
`else
        push_entry = {push_idx, push_lvl};
`endif
    end

    // Pending-event bookkeeping; a new change on a still-pending channel overwrites it and flags a loss
    always_comb begin
        pend_d     = pend_q;
        pend_lvl_d = pend_lvl_q;
        ovf_set    = 1'b0;
`ifdef WUB_SCAN_TIMESTAMP_EN
        ts_d       = ts_q + 1'b1;
        pend_ts_d  = pend_ts_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (push && (push_idx == CH_W'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (qual[i]) begin
                if (pend_q[i] && !(push && (push_idx == CH_W'(i)))) begin
                    ovf_set = 1'b1;
                end
                pend_d[i]     = 1'b1;
                pend_lvl_d[i] = sync2_q[i];
`ifdef WUB_SCAN_TIMESTAMP_EN
                pend_ts_d[i]  = ts_q;
`endif
            end
        end
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // FIFO pointer/occupancy update and entry write
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state registers, all cleared by asynchronous reset
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            sync1_q    <= INIT_LEVEL;
            sync2_q    <= INIT_LEVEL;
            level_q    <= INIT_LEVEL;
            pend_q     <= '0;
            pend_lvl_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef WUB_SCAN_TIMESTAMP_EN
            ts_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_ts_q[i] <= '0;
            end
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            pend_q     <= pend_d;
            pend_lvl_q <= pend_lvl_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
`ifdef WUB_SCAN_TIMESTAMP_EN
            ts_q       <= ts_d;
            pend_ts_q  <= pend_ts_d;
`endif
        end
    end

    // FIFO storage; contents are never observed while empty so it needs no reset
    always_ff @(posedge SYSCLK) begin
        mem_q <= mem_d;
    end

    assign head      = mem_q[rd_ptr_q];
    assign evt_valid = (count_q != '0);
    assign evt_count = count_q;
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign evt_chan  = evt_valid ? head[E_W-1 -: CH_W] : '0;
`ifdef WUB_SCAN_TIMESTAMP_EN
    assign evt_level = evt_valid ? head[TS_W] : 1'b0;
    assign evt_time  = evt_valid ? head[TS_W-1:0] : '0;
`else
    assign evt_level = evt_valid ? head[0] : 1'b0;
`endif

endmodule

// File: tb/tb_wub_input_scanner.sv
// tb/tb_wub_input_scanner.sv - scoreboard bench for wub_input_scanner
module tb_wub_input_scanner;

    localparam int NUM_CH = 5;
    localparam int DBC    = 4;
    localparam int DEPTH  = 2;
    localparam int TS_W   = 16;

    logic              SYSCLK = 1'b0;
    logic              NSYSRESET;
    logic [NUM_CH-1:0] raw_in;
    logic [NUM_CH-1:0] level;
    logic              evt_valid;
    logic              evt_ready;
    logic [2:0]        evt_chan;
    logic              evt_level;
`ifdef WUB_SCAN_TIMESTAMP_EN
    logic [TS_W-1:0]   evt_time;
`endif
    logic [1:0]        evt_count;
    logic              ovf;
    logic              ovf_clr;

    typedef struct {
        logic [2:0] chan;
        logic       lvl;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  pass  = 0;

    wub_input_scanner #(
        .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DBC), .FIFO_DEPTH(DEPTH),
        .INIT_LEVEL(5'b00000), .TS_W(TS_W)
    ) dut (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .raw_in(raw_in), .level(level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
        .evt_level(evt_level),
`ifdef WUB_SCAN_TIMESTAMP_EN
        .evt_time(evt_time),
`endif
        .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SYSCLK);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [2:0] c, input logic l);
        ev_t e;
        e.chan = c;
        e.lvl  = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted head is compared against the next expected event
    always @(negedge SYSCLK) begin
        if (NSYSRESET && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_event", {28'd0, evt_chan, evt_level}, 32'hffff_ffff);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("mon_chan", 32'(evt_chan), 32'(e.chan));
                check("mon_level", 32'(evt_level), 32'(e.lvl));
            end
        end
    end

    initial begin
        NSYSRESET = 1'b0;
        raw_in    = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick(3);
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_count", 32'(evt_count), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_chan", 32'(evt_chan), 0);
        NSYSRESET = 1'b1;
        tick(2);

        // single channel latency: level at edge 6, evt_valid after edge 7
        raw_in[2] = 1'b1;
        tick(5);
        check("t1_level_early", 32'(level[2]), 0);
        tick(1);
        check("t1_level", 32'(level[2]), 1);
        check("t1_valid_early", 32'(evt_valid), 0);
        tick(1);
        check("t1_valid", 32'(evt_valid), 1);
        check("t1_chan", 32'(evt_chan), 2);
        check("t1_evlevel", 32'(evt_level), 1);
        check("t1_count", 32'(evt_count), 1);
        expect_ev(3'd2, 1'b1);
        tick(2);
        check("t1_hold_chan", 32'(evt_chan), 2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("t1_drained", 32'(evt_count), 0);

        // pulse shorter than the window is rejected
        raw_in[0] = 1'b1;
        tick(3);
        raw_in[0] = 1'b0;
        tick(10);
        check("t2_level", 32'(level[0]), 0);
        check("t2_count", 32'(evt_count), 0);

        // simultaneous changes pushed index-ascending on consecutive cycles
        raw_in[4] = 1'b1;
        raw_in[1] = 1'b1;
        expect_ev(3'd1, 1'b1);
        expect_ev(3'd4, 1'b1);
        tick(6);
        check("t3_levels", 32'(level), 32'b10110);
        check("t3_none_yet", 32'(evt_count), 0);
        tick(1);
        check("t3_first_cnt", 32'(evt_count), 1);
        check("t3_first_chan", 32'(evt_chan), 1);
        tick(1);
        check("t3_second_cnt", 32'(evt_count), 2);
        evt_ready = 1'b1;
        tick(2);
        evt_ready = 1'b0;
        check("t3_drained", 32'(evt_count), 0);

        // three changes into a 2-deep FIFO: third waits, enters on simultaneous pop
        raw_in[0] = 1'b1;
        raw_in[2] = 1'b0;
        raw_in[3] = 1'b1;
        expect_ev(3'd0, 1'b1);
        expect_ev(3'd2, 1'b0);
        expect_ev(3'd3, 1'b1);
        tick(9);
        check("t4_full", 32'(evt_count), 2);
        check("t4_ovf", 32'(ovf), 0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("t4_after_pop", 32'(evt_count), 2);
        check("t4_head", 32'(evt_chan), 2);
        check("t4_ovf2", 32'(ovf), 0);

        // channel 3 toggles twice while full: collision, only latest kept
        raw_in[3] = 1'b0;
        tick(6);
        check("t5_lvl_a", 32'(level[3]), 0);
        check("t5_no_ovf", 32'(ovf), 0);
        raw_in[3] = 1'b1;
        tick(6);
        check("t5_lvl_b", 32'(level[3]), 1);
        check("t5_ovf", 32'(ovf), 1);
        check("t5_count", 32'(evt_count), 2);
        expect_ev(3'd3, 1'b1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t5_ovf_clr", 32'(ovf), 0);
        evt_ready = 1'b1;
        tick(3);
        evt_ready = 1'b0;
        check("t5_drained", 32'(evt_count), 0);

        // reset with two queued events and a debounce in progress
        raw_in[0] = 1'b0;
        raw_in[1] = 1'b0;
        tick(8);
        check("t6_queued", 32'(evt_count), 2);
        raw_in[4] = 1'b0;
        tick(2);
        NSYSRESET = 1'b0;
        #1;
        check("t6_level", 32'(level), 0);
        check("t6_valid", 32'(evt_valid), 0);
        check("t6_count", 32'(evt_count), 0);
        check("t6_chan", 32'(evt_chan), 0);
        check("t6_evlevel", 32'(evt_level), 0);
        check("t6_ovf", 32'(ovf), 0);
`ifdef WUB_SCAN_TIMESTAMP_EN
        check("t6_time", 32'(evt_time), 0);
`endif
        exp_q.delete();
        raw_in = '0;
        tick(2);
        NSYSRESET = 1'b1;
        tick(2);
        raw_in[2] = 1'b1;
        expect_ev(3'd2, 1'b1);
        tick(6);
        check("t7_level", 32'(level[2]), 1);
        tick(1);
        check("t7_valid", 32'(evt_valid), 1);
`ifdef WUB_SCAN_TIMESTAMP_EN
        check("t7_time", 32'(evt_time), 7);
`endif
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        tick(2);
        check("end_count", 32'(evt_count), 0);
        check("end_scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/wub_input_scanner.md
# wub_input_scanner

Parametrised N-channel input conditioner for the wubsuit base fabric: synchronises raw piezo, capacitive and push-button inputs, debounces each channel independently, and queues each debounced level change as an event in a FIFO drained by the MSS over a valid/ready handshake. It sits between the top-level sensor pins (RPiezo, LPiezo, CapButton, CButton0/1, …) and the fabric-to-MSS interface. It replaces per-pin ad-hoc polling with one event stream.

## Interface
- NUM_CH, 5, number of input channels (1..16)
- DEBOUNCE_CYCLES, 10000, consecutive stable SYSCLK cycles required to accept a new level (≥2)
- FIFO_DEPTH, 8, event FIFO entries (power of two, ≥2)
- INIT_LEVEL, {NUM_CH{1'b0}}, per-channel debounced level after reset
- TS_W, 16, timestamp width (used only with WUB_SCAN_TIMESTAMP_EN)

- SYSCLK  in  1  single clock, all logic rising-edge
- NSYSRESET  in  1  asynchronous active-low reset
- raw_in  in  NUM_CH  asynchronous raw inputs
- level  out  NUM_CH  current debounced levels
- evt_valid  out  1  FIFO head is valid
- evt_ready  in  1  consumer accepts head this cycle
- evt_chan  out  CH_W=max(1,$clog2(NUM_CH))  channel index of head event
- evt_level  out  1  new level of head event
- evt_time  out  TS_W  timestamp of head event (present only with the macro)
- evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- ovf  out  1  sticky: an event was lost
- ovf_clr  in  1  synchronous clear of ovf

## Operation
- Two-flop synchroniser per channel → s[i]; reset value of sync flops = INIT_LEVEL.
- Debounce counter cnt[i], width $clog2(DEBOUNCE_CYCLES): s[i]==level[i] → cnt←0; else cnt←cnt+1; when s[i]!=level[i] and cnt==DEBOUNCE_CYCLES-1 → level[i]←s[i], cnt←0, pend[i]←1, pend_lvl[i]←s[i]. Any glitch back to level[i] restarts the count.
- Arbiter: each cycle, lowest-index channel with pend set is pushed into the FIFO if not full (after the same-cycle pop is accounted for); its pend clears. One push per cycle max.
- Pend collision: channel qualifies a new change while pend[i] still set → pend_lvl overwritten, old event lost, ovf←1.
- FIFO full: pending events wait (backpressure), no loss unless a collision occurs.
- FIFO is first-word-fall-through; pop on evt_valid&&evt_ready. Push and pop in the same cycle when full is legal; count unchanged.
- ovf: set beats clear when both occur in one cycle.
- Reset (any time, including mid-debounce or with FIFO non-empty): level=INIT_LEVEL, cnt=0, pend=0, FIFO empty, evt_valid=0, evt_chan=0, evt_level=0, evt_time=0, evt_count=0, ovf=0.

## Timing
- raw_in edge sampled at edge k → level updates at edge k+1+DEBOUNCE_CYCLES (2 sync + debounce window, held stable throughout).
- pend set with level; push at next edge if channel wins arbitration and FIFO not full; evt_valid high after that edge.
- Total raw-to-evt_valid latency with empty FIFO and no contention: DEBOUNCE_CYCLES+3 cycles.
- K channels qualifying in the same cycle are pushed on K consecutive cycles, index ascending.
- Head outputs stable while evt_valid && !evt_ready.

## Configuration
- WUB_SCAN_TIMESTAMP_EN defined: free-running TS_W-bit counter (reset 0, wraps to 0 at all ones); value at level-update edge is stored with pend and carried in the FIFO entry; evt_time port exists.
- Undefined: no counter, no evt_time port, FIFO entry is CH_W+1 bits.

## Test plan
- DEBOUNCE_CYCLES=4, raw_in[2] 0→1 held, evt_ready=0 → level[2]=1 after 6 edges, evt_valid after 7, evt_chan=2, evt_level=1, evt_count=1.
- raw_in[0] pulses high for 3 cycles (< window) → level[0] stays 0, no event, evt_count=0.
- raw_in[4] and raw_in[1] rise in the same cycle → two events, chan 1 then chan 4, on consecutive cycles.
- FIFO_DEPTH=2, evt_ready=0, three channels change → count=2, third held pending; assert evt_ready one cycle → third enters, ovf=0.
- Channel 3 toggles twice while FIFO full → ovf=1, only latest level queued; ovf_clr → ovf=0.
- NSYSRESET low with 2 queued events mid-debounce → all outputs reset values immediately; with macro, evt_time of first post-reset event equals counter value at its level-update edge.
